// File: rtl/axil_reg_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register arbiter.
package axil_reg_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axil_reg_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer moves only on an accepted grant,
// so a request withdrawn before acceptance never shifts fairness.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic favour_1;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = favour_1 ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_1 <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            favour_1 <= grant[0];
        end
    end

endmodule

// File: rtl/axil_reg_arbiter.sv
// Arbitrates two register-access requesters onto one AXI4-Lite master port,
// one access outstanding at a time.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for a request; grant given combinationally
// ST_WR      | AW and W issued, each dropped on its own handshake
// ST_WR_RESP | bready high, waiting for B
// ST_RD_ADDR | arvalid held until arready
// ST_RD_DATA | rready high, waiting for R
// ST_DONE    | one-cycle resp_valid pulse to the granted requester
module axil_reg_arbiter
    import axil_reg_arbiter_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_write,
    input  logic [2*C_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*C_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                resp_valid,
    output logic [C_DATA_WIDTH-1:0]   resp_rdata,
    output logic [1:0]                resp_resp,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam logic [C_ADDR_WIDTH-1:0] WORD_MASK = ~C_ADDR_WIDTH'(3);

    arb_state_t                state;
    logic                      gnt_id;
    logic [C_ADDR_WIDTH-1:0]   addr_q;
    logic [C_DATA_WIDTH-1:0]   wdata_q;
    logic [C_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                resp_q;
    logic                      aw_pend;
    logic                      w_pend;
    logic [1:0]                grant;
    logic                      take;
    logic                      sel_id;
    logic [C_ADDR_WIDTH-1:0]   sel_addr;
    logic [C_DATA_WIDTH-1:0]   sel_wdata;
    logic                      aw_clear;
    logic                      w_clear;

    // Reset gates the grant so req_ready stays low while ARESETN is held.
    assign take      = (state == ST_IDLE) && ARESETN && (req_valid != 2'b00);
    assign sel_id    = grant[1];
    assign sel_addr  = sel_id ? req_addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH] : req_addr[C_ADDR_WIDTH-1:0];
    assign sel_wdata = sel_id ? req_wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH] : req_wdata[C_DATA_WIDTH-1:0];
    assign aw_clear  = !aw_pend || m_axi_awready;
    assign w_clear   = !w_pend || m_axi_wready;

    rr_arb2 u_rr_arb2 (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .req     (req_valid),
        .advance (take),
        .grant   (grant)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= ST_IDLE;
            gnt_id  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        gnt_id  <= sel_id;
                        addr_q  <= sel_addr & WORD_MASK;
                        wdata_q <= sel_wdata;
                        if (req_write[sel_id]) begin
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= ST_WR;
                        end else begin
                            state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    aw_pend <= aw_pend && !m_axi_awready;
                    w_pend  <= w_pend && !m_axi_wready;
                    if (aw_clear && w_clear) begin
                        state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        resp_q  <= m_axi_bresp;
                        rdata_q <= '0;
                        state   <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        resp_q  <= m_axi_rresp;
                        rdata_q <= m_axi_rdata;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = take ? grant : 2'b00;
    assign resp_valid    = (state == ST_DONE) ? onehot2(gnt_id) : 2'b00;
    assign resp_rdata    = rdata_q;
    assign resp_resp     = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_awvalid = aw_pend;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_bready  = (state == ST_WR_RESP);
    assign m_axi_arvalid = (state == ST_RD_ADDR);
    assign m_axi_rready  = (state == ST_RD_DATA);

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Scoreboard bench for axil_reg_arbiter: directed requester traffic against a
// small AXI4-Lite register slave with programmable stalls and error injection.
module tb_axil_reg_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [1:0]    req_write = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]    resp_valid;
    logic [DW-1:0] resp_rdata;
    logic [1:0]    resp_resp;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = '0;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;

    axil_reg_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_resp(resp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sq[$];
    int   gq[$];
    exp_t e;
    int   g;
    int   resp_cnt = 0;
    int   last_resp_cyc = 0;
    int   last_grant_cyc = 0;
    int   first_grant_cyc = 0;
    bit   first_mark = 0;
    int   awv_cnt = 0;
    int   wv_cnt = 0;

    // slave model state
    logic [31:0] mem [4];
    int          aw_delay = 0;
    int          b_delay = 0;
    bit          err_on_8 = 0;
    int          aw_cnt = 0;
    int          b_cnt = 0;
    int          b_count = 0;
    bit          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0;
    logic [3:0]  aw_cap = '0, ar_cap = '0;
    logic [31:0] w_cap = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    always @(posedge ACLK) cyc++;

    // Slave acts at negedge: consume handshakes from the last posedge, then
    // set readies/valids and precompute handshakes for the coming posedge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_got = 0; w_got = 0; b_pend = 0; aw_cnt = 0; b_cnt = 0;
        end else begin
            if (aw_hs) begin aw_got = 1; m_axi_awready = 0; aw_cnt = 0; end
            if (w_hs) begin w_got = 1; m_axi_wready = 0; end
            if (b_hs) begin m_axi_bvalid = 0; b_count++; end
            if (r_hs) m_axi_rvalid = 0;
            if (ar_hs) begin
                m_axi_arready = 0;
                m_axi_rvalid = 1;
                if (err_on_8 && ar_cap == 4'h8) begin
                    m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b10;
                end else if (ar_cap[1:0] != 2'b00) begin
                    m_axi_rdata = 32'h0; m_axi_rresp = 2'b11;
                end else begin
                    m_axi_rdata = mem[ar_cap[3:2]]; m_axi_rresp = 2'b00;
                end
            end
            if (aw_got && w_got) begin
                m_axi_bresp = (aw_cap[1:0] != 2'b00) ? 2'b11 : 2'b00;
                if (aw_cap[1:0] == 2'b00) mem[aw_cap[3:2]] = w_cap;
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_delay;
            end
            if (b_pend) begin
                if (b_cnt == 0) begin m_axi_bvalid = 1; b_pend = 0; end
                else b_cnt--;
            end
            if (m_axi_awvalid && !aw_got) begin
                if (aw_cnt >= aw_delay) m_axi_awready = 1;
                else begin m_axi_awready = 0; aw_cnt++; end
            end
            m_axi_wready  = m_axi_wvalid && !w_got;
            m_axi_arready = m_axi_arvalid;
            aw_hs = m_axi_awvalid && m_axi_awready;
            if (aw_hs) aw_cap = m_axi_awaddr;
            w_hs = m_axi_wvalid && m_axi_wready;
            if (w_hs) w_cap = m_axi_wdata;
            b_hs = m_axi_bvalid && m_axi_bready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            if (ar_hs) ar_cap = m_axi_araddr;
            r_hs = m_axi_rvalid && m_axi_rready;
        end
    end

    // monitor: grants and completions popped from the scoreboard queues
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (m_axi_awvalid) awv_cnt++;
            if (m_axi_wvalid) wv_cnt++;
            if (req_ready != 2'b00) begin
                last_grant_cyc = cyc;
                if (first_mark) begin first_grant_cyc = cyc; first_mark = 0; end
                if (gq.size() == 0) chk("unexpected_grant", 64'(req_ready), 64'(0));
                else begin
                    g = gq.pop_front();
                    chk("grant", 64'(req_ready), 64'(2'b01 << g));
                end
            end
            if (resp_valid != 2'b00) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                if (sq.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'(0));
                else begin
                    e = sq.pop_front();
                    chk("resp_valid", 64'(resp_valid), 64'(e.id ? 2'b10 : 2'b01));
                    chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                    chk("resp_resp", 64'(resp_resp), 64'(e.resp));
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'(0));
        chk({tag, "_wvalid"}, 64'(m_axi_wvalid), 64'(0));
        chk({tag, "_bready"}, 64'(m_axi_bready), 64'(0));
        chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'(0));
        chk({tag, "_rready"}, 64'(m_axi_rready), 64'(0));
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'(0));
        chk({tag, "_resp_resp"}, 64'(resp_resp), 64'(0));
        chk({tag, "_awaddr"}, 64'(m_axi_awaddr), 64'(0));
        chk({tag, "_araddr"}, 64'(m_axi_araddr), 64'(0));
    endtask

    task automatic wait_accept(input int id);
        bit ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge ACLK);
            if (req_ready[id]) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout requester=%0d actual=no_ready expected=ready", id);
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && sq.size() != 0; t++) @(negedge ACLK);
        if (sq.size() != 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout actual_pending=%0d expected_pending=0", sq.size());
        end
    endtask

    task automatic access(input int id, input bit wr, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic [1:0] exp_resp, input bit want_resp);
        exp_t x;
        x.id = id[0]; x.rdata = exp_rd; x.resp = exp_resp;
        gq.push_back(id);
        if (want_resp) sq.push_back(x);
        @(posedge ACLK); #1;
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_addr[id*AW +: AW] = addr;
        req_wdata[id*DW +: DW] = wd;
        wait_accept(id);
        @(posedge ACLK); #1;
        req_valid[id] = 1'b0;
        if (want_resp) wait_drain();
    endtask

    task automatic hold_req(input int id, input bit wr, input logic [31:0] wd0, input logic [31:0] wd1);
        for (int k = 0; k < 2; k++) begin
            @(posedge ACLK); #1;
            req_valid[id] = 1'b1;
            req_write[id] = wr;
            req_addr[id*AW +: AW] = 4'h0;
            req_wdata[id*DW +: DW] = (k == 0) ? wd0 : wd1;
            wait_accept(id);
        end
        @(posedge ACLK); #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        bit seen;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        #2 ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        #1 check_reset("por");
        @(negedge ACLK) ARESETN = 1'b1;

        // sequential writes then readbacks from requester 0
        access(0, 1, 4'h0, 32'd1, 32'd0, 2'b00, 1);
        chk("latency", 64'(last_resp_cyc - last_grant_cyc), 64'(3));
        access(0, 1, 4'h4, 32'd2, 32'd0, 2'b00, 1);
        access(0, 1, 4'h8, 32'd3, 32'd0, 2'b00, 1);
        access(0, 1, 4'hC, 32'd4, 32'd0, 2'b00, 1);
        access(0, 0, 4'h0, 32'd0, 32'd1, 2'b00, 1);
        chk("rd_latency", 64'(last_resp_cyc - last_grant_cyc), 64'(3));
        access(0, 0, 4'h4, 32'd0, 32'd2, 2'b00, 1);
        access(0, 0, 4'h8, 32'd0, 32'd3, 2'b00, 1);
        access(0, 0, 4'hC, 32'd0, 32'd4, 2'b00, 1);

        // awready stalled 4 cycles, wready immediate
        aw_delay = 4; awv_cnt = 0; wv_cnt = 0; b_count = 0;
        access(0, 1, 4'h4, 32'h77, 32'd0, 2'b00, 1);
        aw_delay = 0;
        chk("awvalid_cycles", 64'(awv_cnt), 64'(5));
        chk("wvalid_cycles", 64'(wv_cnt), 64'(1));
        chk("b_handshakes", 64'(b_count), 64'(1));

        // SLVERR on 0x8 (requested unaligned as 0xB), then the other requester proceeds
        err_on_8 = 1;
        access(0, 0, 4'hB, 32'd0, 32'hDEAD_BEEF, 2'b10, 1);
        err_on_8 = 0;
        access(1, 0, 4'h4, 32'd0, 32'h77, 2'b00, 1);

        // reset while waiting for B
        b_delay = 10;
        access(0, 1, 4'hC, 32'h99, 32'd0, 2'b00, 0);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge ACLK);
            if (m_axi_bready) seen = 1;
        end
        chk("wr_resp_reached", 64'(seen), 64'(1));
        #2 ARESETN = 1'b0;
        #1 check_reset("mid");
        repeat (2) @(negedge ACLK);
        @(negedge ACLK) ARESETN = 1'b1;
        b_delay = 0;
        rc = resp_cnt;
        repeat (10) @(negedge ACLK);
        chk("no_resp_after_rst", 64'(resp_cnt), 64'(rc));
        access(0, 0, 4'h4, 32'd0, 32'h77, 2'b00, 1);

        // both requesters continuously valid right after a reset
        @(negedge ACLK) ARESETN = 1'b0;
        @(negedge ACLK) ARESETN = 1'b1;
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        sq.push_back('{id: 1'b0, rdata: 32'h0,  resp: 2'b00});
        sq.push_back('{id: 1'b1, rdata: 32'hA5, resp: 2'b00});
        sq.push_back('{id: 1'b0, rdata: 32'h0,  resp: 2'b00});
        sq.push_back('{id: 1'b1, rdata: 32'h5A, resp: 2'b00});
        first_mark = 1;
        fork
            hold_req(0, 1'b1, 32'hA5, 32'h5A);
            hold_req(1, 1'b0, 32'h0, 32'h0);
        join
        wait_drain();
        chk("b2b_span", 64'(last_resp_cyc - first_grant_cyc), 64'(15));

        repeat (3) @(negedge ACLK);
        chk("sb_empty", 64'(sq.size()), 64'(0));
        chk("grant_q_empty", 64'(gq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_arbiter.md
AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 4, AXI4-Lite byte-address width (four 32-bit registers, 0x0-0xC).
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, register data width.
REQ-003 ACLK  in  1  single clock; all logic rising-edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  2  per-requester access request, held until accepted.
REQ-006 req_ready  out  2  one-hot acceptance pulse, one cycle.
REQ-007 req_write  in  2  per-requester: 1 = write, 0 = read.
REQ-008 req_addr  in  2*C_ADDR_WIDTH  per-requester byte address; requester n at bits [n*AW +: AW].
REQ-009 req_wdata  in  2*C_DATA_WIDTH  per-requester write data; requester n at bits [n*DW +: DW].
REQ-010 resp_valid  out  2  one-hot completion pulse, one cycle, no backpressure.
REQ-011 resp_rdata  out  C_DATA_WIDTH  read data, qualified by resp_valid; 0 for writes.
REQ-012 resp_resp  out  2  BRESP/RRESP of the completed access.
REQ-013 Master AXI4-Lite write-address channel: m_axi_awaddr (out, AW), m_axi_awvalid (out, 1), m_axi_awready (in, 1).
REQ-014 Master AXI4-Lite write-data channel: m_axi_wdata (out, DW), m_axi_wvalid (out, 1), m_axi_wready (in, 1).
REQ-015 Master AXI4-Lite write-response channel: m_axi_bresp (in, 2), m_axi_bvalid (in, 1), m_axi_bready (out, 1).
REQ-016 Master AXI4-Lite read-address channel: m_axi_araddr (out, AW), m_axi_arvalid (out, 1), m_axi_arready (in, 1).
REQ-017 Master AXI4-Lite read-data channel: m_axi_rdata (in, DW), m_axi_rresp (in, 2), m_axi_rvalid (in, 1), m_axi_rready (out, 1).
REQ-018 PROT and WSTRB SHALL NOT be ports; integration ties slave PROT to 3'b000 and WSTRB to all-ones.

Function
REQ-019 FSM states SHALL be IDLE, WR (AW/W issue), WR_RESP, RD_ADDR, RD_DATA, DONE; one access outstanding at most.
REQ-020 In IDLE with any req_valid set, the arbiter SHALL grant within the same cycle, assert req_ready for that requester only, capture write/addr/wdata, and leave IDLE.
REQ-021 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; the first grant after reset SHALL go to requester 0.
REQ-022 Captured address SHALL be driven with bits [1:0] forced to 0.
REQ-023 WR: awvalid and wvalid SHALL both rise the cycle after grant; each SHALL drop independently on its own handshake; WR_RESP is entered once both have completed, in the same or in separate cycles.
REQ-024 WR_RESP: bready SHALL be high until the bvalid handshake, then bresp is captured.
REQ-025 RD_ADDR: arvalid SHALL be held until arready; RD_DATA: rready SHALL be high until rvalid, then rdata/rresp are captured.
REQ-026 DONE: resp_valid SHALL pulse for the granted requester for one cycle with captured data/resp; the FSM then returns to IDLE.
REQ-027 With an always-ready slave returning B/R one cycle after the address handshake, grant-to-resp_valid latency SHALL be 3 cycles; back-to-back accesses SHALL have no idle cycle other than DONE.
REQ-028 SLVERR/DECERR SHALL be passed through unchanged, without retry; AXI VALID signals SHALL never drop before their handshake.
REQ-029 A requester deasserting req_valid before acceptance SHALL lose its request silently; arbitration fairness SHALL be unaffected.

Reset
REQ-030 On ARESETN low (asynchronous): FSM to IDLE; all AXI valid/ready outputs, req_ready, and resp_valid to 0; resp_rdata, resp_resp, and addresses to 0; round-robin pointer to favour requester 0; in-flight access abandoned, with no response issued after release.

Structure
REQ-031 Package axil_reg_arbiter_pkg SHALL hold the FSM state enum and the AXI response constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11).
REQ-032 Sub-module rr_arb2 SHALL implement the two-input round-robin grant and pointer; everything else SHALL be in the top module.

Verification
REQ-033 Requester 0 writes 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then reads them back -> rdata 1, 2, 3, 4 with resp OKAY.
REQ-034 Both requesters valid continuously, R0 writes 0xA5 to 0x0, R1 reads 0x0 -> grants alternate 0, 1, 0, 1 and R1 reads 0xA5 after R0's write.
REQ-035 Slave delays awready 4 cycles with wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles, exactly one B handshake.
REQ-036 Slave returns RRESP=2'b10 on a read of 0x8 -> resp_resp=2'b10 on the same resp_valid pulse, next grant proceeds.
REQ-037 ARESETN asserted in WR_RESP -> all valids 0 immediately, no resp_valid after release, next access to 0x4 completes normally.
